// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/func
// constants, ALU operation codes, FSM states, instruction classes and the
// registered decode bundle.
package mips_pkg;

  localparam int PKG_ALUOP_W = 5;
  typedef logic [PKG_ALUOP_W-1:0] aluop_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;

  // ALU operation set
  localparam aluop_t ALU_NOP   = aluop_t'(0);
  localparam aluop_t ALU_ADD   = aluop_t'(1);
  localparam aluop_t ALU_SUB   = aluop_t'(2);
  localparam aluop_t ALU_AND   = aluop_t'(3);
  localparam aluop_t ALU_OR    = aluop_t'(4);
  localparam aluop_t ALU_XOR   = aluop_t'(5);
  localparam aluop_t ALU_NOR   = aluop_t'(6);
  localparam aluop_t ALU_SLT   = aluop_t'(7);
  localparam aluop_t ALU_SLTU  = aluop_t'(8);
  localparam aluop_t ALU_SLL   = aluop_t'(9);
  localparam aluop_t ALU_SRL   = aluop_t'(10);
  localparam aluop_t ALU_SRA   = aluop_t'(11);
  localparam aluop_t ALU_LUI   = aluop_t'(12);
  localparam aluop_t ALU_MULT  = aluop_t'(13);
  localparam aluop_t ALU_MULTU = aluop_t'(14);
  localparam aluop_t ALU_DIV   = aluop_t'(15);
  localparam aluop_t ALU_DIVU  = aluop_t'(16);

  typedef enum logic [2:0] {
    ST_FETCH       = 3'd0,
    ST_DECODE      = 3'd1,
    ST_EXEC        = 3'd2,
    ST_MULDIV_WAIT = 3'd3,
    ST_MEM         = 3'd4,
    ST_WB          = 3'd5,
    ST_HALT        = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU       = 4'd0,
    CL_LOAD      = 4'd1,
    CL_STORE     = 4'd2,
    CL_BRANCH    = 4'd3,
    CL_JUMP      = 4'd4,
    CL_JUMP_LINK = 4'd5,
    CL_JUMP_REG  = 4'd6,
    CL_MULDIV    = 4'd7,
    CL_HALT      = 4'd8,
    CL_ILLEGAL   = 4'd9
  } iclass_t;

  typedef struct packed {
    logic   reg_dest;
    logic   alu_src;
    logic   link;
    logic   mem_to_reg;
    logic   jump;
    logic   jump_reg;
    aluop_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: opcode/func to instruction class plus
// the datapath select bundle. Unknown encodings yield CL_ILLEGAL and an
// all-zero bundle.
module cu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output ctrl_t      ctrl
);

  // Decode table lookup
  always_comb begin
    iclass = CL_ILLEGAL;
    ctrl   = '0;
    case (opcode)
      OP_RTYPE: begin
        iclass        = CL_ALU;
        ctrl.reg_dest = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_SRA:          ctrl.alu_op = ALU_SRA;
          FN_MULT: begin
            iclass      = CL_MULDIV;
            ctrl.alu_op = ALU_MULT;
          end
          FN_MULTU: begin
            iclass      = CL_MULDIV;
            ctrl.alu_op = ALU_MULTU;
          end
          FN_DIV: begin
            iclass      = CL_MULDIV;
            ctrl.alu_op = ALU_DIV;
          end
          FN_DIVU: begin
            iclass      = CL_MULDIV;
            ctrl.alu_op = ALU_DIVU;
          end
          FN_JR: begin
            iclass        = CL_JUMP_REG;
            ctrl.reg_dest = 1'b0;
            ctrl.jump_reg = 1'b1;
          end
          FN_SYSCALL: begin
            iclass = CL_HALT;
            ctrl   = '0;
          end
          default: begin
            iclass = CL_ILLEGAL;
            ctrl   = '0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      OP_SLTI: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_SLT;
      end
      OP_SLTIU: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_SLTU;
      end
      OP_ANDI: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_AND;
      end
      OP_ORI: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_OR;
      end
      OP_XORI: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_XOR;
      end
      OP_LUI: begin
        iclass       = CL_ALU;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_LUI;
      end
      OP_LW: begin
        iclass          = CL_LOAD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        iclass       = CL_STORE;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        iclass      = CL_BRANCH;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J: begin
        iclass    = CL_JUMP;
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        iclass    = CL_JUMP_LINK;
        ctrl.jump = 1'b1;
        ctrl.link = 1'b1;
      end
      default: begin
        iclass = CL_ILLEGAL;
        ctrl   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit. Decodes each instruction once in DECODE,
// then sequences EXEC/MEM/MULDIV_WAIT/WB. Memory latency is absorbed by the
// mem_req/mem_ready handshake; MULT/DIV latency by a down-counter.
module mc_control_unit
  import mips_pkg::*;
#(
  parameter int ALUOP_W       = 5,
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               muldiv_start,
  output logic               reg_dest,
  output logic               alu_src,
  output logic               link,
  output logic               mem_to_reg,
  output logic               branch,
  output logic               jump,
  output logic               jump_reg,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               halted,
  output logic [2:0]         state_o
);

  state_t           state;
  iclass_t          class_q;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt;
  iclass_t          dec_class;
  ctrl_t            dec_ctrl;

  cu_decoder u_dec (
    .opcode (opcode),
    .func   (func),
    .iclass (dec_class),
    .ctrl   (dec_ctrl)
  );

  // FSM: state sequencing, decode-bundle latch and MULT/DIV wait counter
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= ST_FETCH;
      class_q <= CL_ALU;
      ctrl_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) state <= ST_DECODE;
        end
        ST_DECODE: begin
          class_q <= dec_class;
          ctrl_q  <= dec_ctrl;
          if (dec_class == CL_HALT || dec_class == CL_ILLEGAL) state <= ST_HALT;
          else                                                 state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (class_q)
            CL_ALU:            state <= ST_WB;
            CL_LOAD, CL_STORE: state <= ST_MEM;
            CL_MULDIV: begin
              cnt   <= CNT_W'(MULDIV_CYCLES - 1);
              state <= ST_MULDIV_WAIT;
            end
            default:           state <= ST_FETCH;
          endcase
        end
        ST_MULDIV_WAIT: begin
          if (cnt == '0) state <= ST_WB;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_MEM: begin
          if (mem_ready) state <= (class_q == CL_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Output decode from state and latched bundle; everything is zero in reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    muldiv_start = 1'b0;
    branch       = 1'b0;
    reg_write    = 1'b0;
    halted       = 1'b0;
    state_o      = 3'd0;
    reg_dest     = 1'b0;
    alu_src      = 1'b0;
    link         = 1'b0;
    mem_to_reg   = 1'b0;
    jump         = 1'b0;
    jump_reg     = 1'b0;
    alu_op       = '0;
    if (rst_b) begin
      state_o = state;
      if (state != ST_FETCH) begin
        reg_dest   = ctrl_q.reg_dest;
        alu_src    = ctrl_q.alu_src;
        link       = ctrl_q.link;
        mem_to_reg = ctrl_q.mem_to_reg;
        jump       = ctrl_q.jump;
        jump_reg   = ctrl_q.jump_reg;
        alu_op     = ALUOP_W'(ctrl_q.alu_op);
      end
      case (state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_EXEC: begin
          case (class_q)
            CL_BRANCH:    branch       = 1'b1;
            CL_JUMP:      pc_write     = 1'b1;
            CL_JUMP_REG:  pc_write     = 1'b1;
            CL_MULDIV:    muldiv_start = 1'b1;
            CL_JUMP_LINK: begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_we  = (class_q == CL_STORE);
        end
        ST_WB:   reg_write = 1'b1;
        ST_HALT: halted    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit with MULDIV_CYCLES = 4.
module tb_mc_control_unit;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, muldiv_start;
  logic       reg_dest, alu_src, link, mem_to_reg, branch, jump, jump_reg;
  logic [4:0] alu_op;
  logic       reg_write, halted;
  logic [2:0] state_o;

  int n_pass  = 0;
  int n_total = 0;

  // Strobe vector order: mem_req mem_we i_or_d ir_write pc_write muldiv_start branch reg_write
  localparam logic [7:0] SB_NONE   = 8'h00;
  localparam logic [7:0] SB_FETCH  = 8'h98;
  localparam logic [7:0] SB_FWAIT  = 8'h80;
  localparam logic [7:0] SB_MEM_LD = 8'hA0;
  localparam logic [7:0] SB_MEM_ST = 8'hE0;
  localparam logic [7:0] SB_MULDIV = 8'h04;
  localparam logic [7:0] SB_BRANCH = 8'h02;
  localparam logic [7:0] SB_JAL    = 8'h09;
  localparam logic [7:0] SB_WB     = 8'h01;

  always #5 clk = ~clk;

  mc_control_unit #(
    .ALUOP_W       (5),
    .MULDIV_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .opcode       (opcode),
    .func         (func),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .muldiv_start (muldiv_start),
    .reg_dest     (reg_dest),
    .alu_src      (alu_src),
    .link         (link),
    .mem_to_reg   (mem_to_reg),
    .branch       (branch),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .halted       (halted),
    .state_o      (state_o)
  );

  function automatic logic [7:0] strobes();
    return {mem_req, mem_we, i_or_d, ir_write, pc_write, muldiv_start, branch, reg_write};
  endfunction

  function automatic logic [5:0] selects();
    return {reg_dest, alu_src, link, mem_to_reg, jump, jump_reg};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Let combinational outputs settle, then check state and strobes.
  task automatic look(input string tag, input logic [2:0] st, input logic [7:0] sb);
    #1;
    check({tag, "_state"}, 32'(state_o), 32'(st));
    check({tag, "_strobes"}, 32'(strobes()), 32'(sb));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b111111;
    func      = 6'b000000;
    repeat (2) @(posedge clk);
    #1;

    // Reset: every output forced low
    look("rst", 3'd0, SB_NONE);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_sel", 32'(selects()), 32'd0);
    check("rst_aluop", 32'(alu_op), 32'd0);
    rst_b = 1'b1;

    // ADD: 4 cycles
    opcode = 6'b000000;
    func   = 6'b100000;
    look("add_c1", 3'd0, SB_FETCH);
    adv();
    look("add_c2", 3'd1, SB_NONE);
    adv();
    look("add_c3", 3'd2, SB_NONE);
    adv();
    look("add_c4", 3'd4 + 3'd1, SB_WB);
    check("add_regdest", 32'(reg_dest), 32'd1);
    check("add_aluop", 32'(alu_op), 32'(ALU_ADD));
    adv();

    // LW with three not-ready cycles in MEM: 8 cycles
    opcode = 6'b100011;
    look("lw_c1", 3'd0, SB_FETCH);
    check("fetch_sel_zero", 32'(selects()), 32'd0);
    check("fetch_aluop_zero", 32'(alu_op), 32'd0);
    adv();
    look("lw_c2", 3'd1, SB_NONE);
    adv();
    mem_ready = 1'b0;
    look("lw_c3", 3'd2, SB_NONE);
    adv();
    for (int i = 0; i < 3; i++) begin
      look("lw_memwait", 3'd4, SB_MEM_LD);
      adv();
    end
    mem_ready = 1'b1;
    look("lw_memdone", 3'd4, SB_MEM_LD);
    adv();
    look("lw_wb", 3'd5, SB_WB);
    check("lw_memtoreg", 32'(mem_to_reg), 32'd1);
    check("lw_alusrc", 32'(alu_src), 32'd1);
    adv();

    // SW: 4 cycles, never a reg_write
    opcode = 6'b101011;
    look("sw_c1", 3'd0, SB_FETCH);
    adv();
    look("sw_c2", 3'd1, SB_NONE);
    adv();
    look("sw_c3", 3'd2, SB_NONE);
    adv();
    look("sw_c4", 3'd4, SB_MEM_ST);
    adv();

    // MULT with 4 wait cycles: reg_write in cycle 8
    opcode = 6'b000000;
    func   = 6'b011000;
    look("mult_c1", 3'd0, SB_FETCH);
    adv();
    look("mult_c2", 3'd1, SB_NONE);
    adv();
    look("mult_c3", 3'd2, SB_MULDIV);
    adv();
    for (int i = 0; i < 4; i++) begin
      look("mult_wait", 3'd3, SB_NONE);
      adv();
    end
    look("mult_c8", 3'd5, SB_WB);
    check("mult_aluop", 32'(alu_op), 32'(ALU_MULT));
    adv();

    // JAL: 3 cycles, pc_write and reg_write in EXEC
    opcode = 6'b000011;
    look("jal_c1", 3'd0, SB_FETCH);
    adv();
    look("jal_c2", 3'd1, SB_NONE);
    adv();
    look("jal_c3", 3'd2, SB_JAL);
    check("jal_link_jump", 32'({link, jump, jump_reg}), 32'b110);
    adv();

    // BEQ: branch pulse in cycle 3
    opcode = 6'b000100;
    look("beq_c1", 3'd0, SB_FETCH);
    adv();
    look("beq_c2", 3'd1, SB_NONE);
    adv();
    look("beq_c3", 3'd2, SB_BRANCH);
    check("beq_aluop", 32'(alu_op), 32'(ALU_SUB));
    adv();

    // Illegal opcode: HALT is sticky regardless of mem_ready
    opcode = 6'b111111;
    look("ill_c1", 3'd0, SB_FETCH);
    adv();
    look("ill_c2", 3'd1, SB_NONE);
    adv();
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      look("halt", 3'd6, SB_NONE);
      check("halt_flag", 32'(halted), 32'd1);
      adv();
    end

    // One reset cycle clears HALT
    rst_b = 1'b0;
    look("halt_rst", 3'd0, SB_NONE);
    check("halt_rst_flag", 32'(halted), 32'd0);
    adv();
    rst_b     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b100011;
    look("post_rst_c1", 3'd0, SB_FETCH);
    check("post_rst_flag", 32'(halted), 32'd0);
    adv();

    // Reset during MEM of LW abandons the access
    look("lwr_c2", 3'd1, SB_NONE);
    adv();
    mem_ready = 1'b0;
    look("lwr_c3", 3'd2, SB_NONE);
    adv();
    look("lwr_mem", 3'd4, SB_MEM_LD);
    adv();
    rst_b = 1'b0;
    look("lwr_rst", 3'd0, SB_NONE);
    adv();
    rst_b = 1'b1;
    look("lwr_refetch", 3'd0, SB_FWAIT);
    adv();
    look("lwr_refetch2", 3'd0, SB_FWAIT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit.
- Decodes opcode/func once per instruction, then sequences FETCH, DECODE, EXEC, MEM and WB through an FSM.
- Handles variable-latency memory via a req/ready handshake and multi-cycle MULT/DIV via a parametrised wait counter.
- Drives the shared-memory multi-cycle datapath: PC, IR, register file, ALU, and a single unified memory.

Parameters:
- ALUOP_W, 5: width of alu_op; must hold every code in the shared ALU op set.
- MULDIV_CYCLES, 32: cycles spent in MULDIV_WAIT, range 1..255.
- CNT_W, 8: MULDIV counter width; must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_b  in  1  reset, synchronous, active-low
- opcode  in  6  IR[31:26]; sampled only in DECODE
- func  in  6  IR[5:0]; sampled only in DECODE
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- muldiv_start  out  1  one-cycle start pulse to the mul/div unit
- reg_dest, alu_src, link, mem_to_reg, branch, jump, jump_reg  out  1 each  datapath selects, same meaning as the single-cycle CU
- alu_op  out  ALUOP_W  ALU operation
- reg_write  out  1  register-file write strobe
- halted  out  1  sticky halt
- state_o  out  3  current FSM state, for debug

Behaviour:
- Reset: when rst_b is low at a rising edge, state becomes FETCH, the counter and the latched decode clear, and halted clears. While rst_b is low, every output is forced to 0.
- Strobes: mem_req, mem_we, ir_write, pc_write, muldiv_start, reg_write and branch are Moore-decoded from state.
- Selects: reg_dest, alu_src, link, mem_to_reg, alu_op, jump and jump_reg come from a decode bundle registered at the end of DECODE. They hold until the next DECODE and read 0 in FETCH.
- FETCH: mem_req=1, i_or_d=0. Stay in FETCH while mem_ready=0. On mem_ready=1, assert ir_write=1 and pc_write=1 (PC+4) in that same cycle, then go to DECODE.
- DECODE: latch the decode bundle. Next state is HALT if the instruction is illegal or SYSCALL (func 001100); otherwise EXEC.
- EXEC, by instruction class:
  - ALU: go to WB.
  - LW/SW: go to MEM.
  - BEQ/BNE/BLEZ/BGTZ: branch=1 for one cycle (datapath gates pc_write with zero), then FETCH.
  - J: pc_write=1, then FETCH.
  - JAL: pc_write=1 and reg_write=1, then FETCH.
  - JR: pc_write=1, jump_reg=1, then FETCH.
  - MULT/DIV: muldiv_start=1, counter loads MULDIV_CYCLES-1, then MULDIV_WAIT.
- MULDIV_WAIT: counter decrements each cycle; when the counter reads 0, go to WB.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for SW only. Hold while mem_ready=0. On ready, SW goes to FETCH and LW goes to WB.
- WB: reg_write=1 for exactly one cycle, then FETCH.
- HALT: all strobes 0, halted=1. Sticky; only reset leaves HALT.
- mem_ready is ignored outside FETCH and MEM.
- Reset mid-transaction abandons the transaction: mem_req drops in the reset cycle and the FSM restarts in FETCH.
- Latencies with mem_ready tied high:
  - ALU R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/jump: 3 cycles.
  - MULT/DIV: 4+MULDIV_CYCLES cycles.
- Each cycle that mem_ready is low adds one cycle, in FETCH or MEM respectively.
- Decode tables (ALU op per instruction, RegDest/ALUsrc/Link/MemToReg) are identical to the single-cycle CU. SUBU maps to ALU_SUB, ADDU and ADDiu to ALU_ADD.

Decomposition:
- mips_pkg holds:
  - opcode and func constants;
  - ALU op codes sized by ALUOP_W;
  - state enum: FETCH, DECODE, EXEC, MULDIV_WAIT, MEM, WB, HALT;
  - instruction-class enum: ALU, LOAD, STORE, BRANCH, JUMP, JUMP_LINK, JUMP_REG, MULDIV, HALT, ILLEGAL;
  - packed ctrl_t struct for the decode bundle.
- Sub-module cu_decoder: purely combinational opcode/func to {class, ctrl_t}. Its output is registered by mc_control_unit in DECODE.

Test Plan:
- ADD (opcode 000000, func 100000), mem_ready=1 -> mem_req+ir_write in cycle 1; reg_write pulse in cycle 4 with reg_dest=1, alu_op=ALU_ADD; FETCH in cycle 5.
- LW (opcode 100011), mem_ready low 3 cycles in MEM -> mem_req=1, i_or_d=1, mem_we=0 for 4 cycles; then WB with mem_to_reg=1, reg_write=1; total 8 cycles.
- SW (opcode 101011) -> MEM with mem_we=1; no reg_write at any point; back to FETCH after 4 cycles.
- MULT (func 011000), MULDIV_CYCLES=4 -> muldiv_start high exactly in cycle 3; 4 cycles in MULDIV_WAIT; reg_write in cycle 8.
- BEQ (opcode 000100), then opcode 111111 -> branch pulse in cycle 3, FETCH in cycle 4; next instruction gives halted=1 from cycle 3 onward with all strobes 0 despite toggling mem_ready; one rst_b=0 cycle clears halted and state_o=FETCH.
- Reset asserted during MEM of an LW with mem_ready=0 -> mem_req=0 in that cycle; FETCH next cycle; no reg_write occurs.
